// File: rtl/dmem_wait_model.sv
// dmem_wait_model: byte-enable data memory with read/write wait states, range error and post-reset clear.
// Define DMEM_TRACE_EN to print committed writes and range errors.
module dmem_wait_model #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_LATENCY  = 2,
    parameter int          WR_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d, be_q, be, lat;
    logic [31:0]   addr_q, wdata_q, pc_q, rdata_q, rdata_d;
    logic          err_q, err_d, idle, accept, go_resp, commit, err;
    logic [31:0]   a, wd, pc, off, old, merged;
    logic [31:0]   mem [DEPTH_WORDS];
    // With zero latency the request commits on its accept edge, so use live inputs in IDLE.
    always_comb begin
        idle    = state_q == IDLE;
        accept  = idle && req_valid;
        a       = idle ? req_addr : addr_q;
        wd      = idle ? req_wdata : wdata_q;
        be      = idle ? req_byteen : be_q;
        pc      = idle ? req_pc : pc_q;
        off     = a - BASE_ADDR;
        err     = off >= 32'(DEPTH_WORDS * 4);
        old     = mem[off[AW+1:2]];
        merged  = old;
        for (int i = 0; i < 4; i++) merged[8*i+:8] = be[i] ? wd[8*i+:8] : old[8*i+:8];
        lat     = (be != 4'd0) ? 4'(WR_LATENCY) : 4'(RD_LATENCY);
        go_resp = (accept && lat == 4'd0) || (state_q == WAIT && cnt_q == 4'd0);
        commit  = go_resp && be != 4'd0 && !err;
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdata_d = go_resp ? (err ? 32'd0 : (be != 4'd0 ? merged : old)) : rdata_q;
        err_d   = go_resp ? err : err_q;
        case (state_q)
            CLEAR: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == AW'(DEPTH_WORDS - 1)) ? IDLE : CLEAR;
            end
            IDLE: if (req_valid) begin
                state_d = (lat == 4'd0) ? RESP : WAIT;
                cnt_d   = lat - 4'd1;
            end
            WAIT: begin
                state_d = (cnt_q == 4'd0) ? RESP : WAIT;
                cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_byteen;
                pc_q    <= req_pc;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) mem[idx_q] <= '0;
        else if (commit) mem[off[AW+1:2]] <= merged;
    end
`ifdef DMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (commit) $display("%d@%h: *%h <= %h", $time, pc, a & 32'hfffffffc, merged);
        else if (go_resp && err) $display("%d@%h: dmem range error %h", $time, pc, a);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif
    assign req_ready = idle;
    assign busy      = !idle;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_wait_model.sv
// tb_dmem_wait_model: scoreboard bench; u0 uses default latencies, u1 is a small zero-read-latency instance.
module tb_dmem_wait_model;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;
    logic [1:0]       v = '0, rdy, rv, er, bz;
    logic [1:0][31:0] ad = '0, wd = '0, pcs = '0, rd;
    logic [1:0][3:0]  be = '0;
    typedef struct {logic [31:0] rdata; logic err; int edge_n;} exp_t;
    exp_t q0[$], q1[$];
    int cyc = 0, vec = 0, bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_wait_model u0 (.clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]),
        .req_addr(ad[0]), .req_wdata(wd[0]), .req_byteen(be[0]), .req_pc(pcs[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bz[0]));
    dmem_wait_model #(.DEPTH_WORDS(16), .RD_LATENCY(0), .WR_LATENCY(1)) u1 (.clk(clk), .reset(reset),
        .req_valid(v[1]), .req_ready(rdy[1]), .req_addr(ad[1]), .req_wdata(wd[1]), .req_byteen(be[1]),
        .req_pc(pcs[1]), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bz[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp(input string name, input exp_t e, input logic [31:0] r, input logic rerr);
        chk({name, " rdata"}, r, e.rdata);
        chk({name, " err"}, 32'(rerr), 32'(e.err));
        chk({name, " rsp edge"}, cyc, e.edge_n);
    endtask

    always @(negedge clk) begin
        if (rv[0]) begin
            if (q0.size() == 0) begin
                vec++; bad++;
                $display("FAIL u0 spurious rsp: got rsp_valid=1 expected 0");
            end else cmp("u0", q0.pop_front(), rd[0], er[0]);
        end
        if (rv[1]) begin
            if (q1.size() == 0) begin
                vec++; bad++;
                $display("FAIL u1 spurious rsp: got rsp_valid=1 expected 0");
            end else cmp("u1", q1.pop_front(), rd[1], er[1]);
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge k.
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         input logic [31:0] xr, input logic xe, input int lat, output int k);
        int n = 0;
        exp_t e;
        v[i] = 1'b1; ad[i] = a; wd[i] = d; be[i] = b; pcs[i] = 32'h0040_0000 + a;
        while (!rdy[i] && n < 6000) begin
            @(negedge clk);
            n++;
        end
        k = cyc + 1;
        if (!rdy[i]) begin
            vec++; bad++;
            $display("FAIL u%0d accept timeout: got req_ready=0 expected 1", i);
        end else begin
            e = '{xr, xe, k + lat};
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(negedge clk);
        v[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain pending", 32'(q0.size() + q1.size()), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " req_ready"}, 32'(rdy[0]), 0);
        chk({tag, " rsp_valid"}, 32'(rv[0]), 0);
        chk({tag, " rsp_rdata"}, rd[0], 0);
        chk({tag, " rsp_err"}, 32'(er[0]), 0);
        chk({tag, " busy"}, 32'(bz[0]), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, kp;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        reset = 1'b1;
        v[0] = 1'b1; ad[0] = 32'h0; be[0] = 4'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[0] && n < 5000);
        chk("clear cycles", n, 4096);
        issue(0, 32'h0,    32'h0,        4'h0, 32'h0,        1'b0, 2, k);
        issue(0, 32'h10,   32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 1, k);
        issue(0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, k);
        issue(0, 32'h20,   32'h11112222, 4'h3, 32'h00002222, 1'b0, 1, k);
        issue(0, 32'h20,   32'hAB000000, 4'h8, 32'hAB002222, 1'b0, 1, k);
        issue(0, 32'h22,   32'h0,        4'h0, 32'hAB002222, 1'b0, 2, k);
        issue(0, 32'h30,   32'hAABBCCDD, 4'h5, 32'h00BB00DD, 1'b0, 1, k);
        issue(0, 32'h33,   32'h0,        4'h0, 32'h00BB00DD, 1'b0, 2, k);
        issue(0, 32'h0,    32'h12345678, 4'hF, 32'h12345678, 1'b0, 1, k);
        issue(0, 32'h3FFC, 32'h0,        4'h0, 32'h0,        1'b0, 2, k);
        issue(0, 32'h4000, 32'h0,        4'h0, 32'h0,        1'b1, 2, k);
        issue(0, 32'h4000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1, k);
        issue(0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0, 2, k);
        drain();
        repeat (3) @(negedge clk);
        chk("hold rsp_rdata", rd[0], 32'h12345678);
        chk("hold rsp_valid", 32'(rv[0]), 0);
        issue(1, 32'h4, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0, 1, k);
        issue(1, 32'h0, 32'h0, 4'h0, 32'h0,        1'b0, 0, kp);
        issue(1, 32'h4, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0, k);
        chk("b2b interval 1", k - kp, 2);
        kp = k;
        issue(1, 32'h0, 32'h0, 4'h0, 32'h0,        1'b0, 0, k);
        chk("b2b interval 2", k - kp, 2);
        kp = k;
        issue(1, 32'h4, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0, k);
        chk("b2b interval 3", k - kp, 2);
        drain();
        issue(0, 32'h8, 32'h55AA55AA, 4'hF, 32'h55AA55AA, 1'b0, 1, k);
        reset = 1'b0;
        #1;
        q0.delete();
        chk_reset_outs("mid-wait reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 2, k);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/dmem_wait_model.md
Name: dmem_wait_model

Overview:
- Parametrised data-memory model for the MIPS core's data port.
- Byte-enable word writes and a valid/ready request handshake.
- Independent, configurable read and write latencies (wait states) and an address-range error response.
- Clears itself sequentially after reset.
- Sits between the core's data-side bus and the bench; replaces the flat zero-wait array model so stall and forwarding paths get exercised.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words stored (power of two, 16..65536)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
RD_LATENCY, 2, cycles spent in WAIT for reads (0..15)
WR_LATENCY, 1, cycles spent in WAIT for writes (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  write data, byte lanes aligned to word
req_byteen  input  4  byte enables; nonzero = write, zero = read
req_pc  input  32  PC of the issuing instruction (trace only)
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  read word, or merged word for writes
rsp_err  output  1  address out of range, valid with rsp_valid
busy  output  1  high in CLEAR, WAIT and RESP

Behaviour:
- Reset (reset==0, async) forces:
  - state=CLEAR, clear index=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
  - Any in-flight request is dropped; its write never commits.
- States: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Writes 0 to word[index] each cycle; index increments.
  - After word DEPTH_WORDS-1 is written, goes to IDLE. CLEAR therefore lasts exactly DEPTH_WORDS cycles after reset release.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid&&req_ready at edge k: latch addr, wdata, byteen and pc, and compute err.
  - Latency L = WR_LATENCY if byteen!=0, else RD_LATENCY.
  - If L==0, go to RESP at edge k; otherwise go to WAIT with cnt=L-1.
- WAIT:
  - req_ready=0.
  - If cnt==0, go to RESP, else cnt decrements. RESP is therefore entered at edge k+L.
- Transition into RESP:
  - offset = addr - BASE_ADDR (32-bit wrap); err = (offset >= DEPTH_WORDS*4).
  - Write, no err: for each lane i with byteen[i] set, replace byte i of word[offset>>2]. rsp_rdata = merged word, committed at that same edge.
  - Read, no err: rsp_rdata = word[offset>>2].
  - err: no memory update, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1 for exactly one cycle, then go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next RESP.
  - rsp_err is meaningful only with rsp_valid.
- Throughput: one request per L+2 cycles. req_ready is low from edge k until the RESP->IDLE edge.
- Ordering: a read issued after a write's response sees the written data.
- req_valid in CLEAR/WAIT/RESP is ignored. The requester must hold it until accepted.
- Misaligned addresses are treated as aligned. Unaligned byteen patterns (e.g. 4'b0101) are honoured lane by lane.
- Reset mid-CLEAR restarts the clear from index 0.

Optional Feature:
DMEM_TRACE_EN
- Defined: each committed, non-error write prints one line at the commit edge: "%d@%h: *%h <= %h" with $time, latched pc, (addr & 32'hfffffffc), merged word.
- Defined: each error response prints "%d@%h: dmem range error %h" with $time, pc, addr.
- Not defined: no $display statements are compiled; all other behaviour is identical.

Test Plan:
- Release reset, hold req_valid=1 -> req_ready=0 for exactly 4096 cycles, then 1; a read of 0x0 then returns 0.
- RD_LATENCY=2, WR_LATENCY=1: write 0x10 data 0xDEADBEEF byteen 4'hF, then read 0x10 -> write rsp_valid at edge k+1, read rsp_valid at edge k+2 after its accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Partial writes to 0x20: byteen 4'b0011 data 0x11112222, then byteen 4'b1000 data 0xAB000000 -> read 0x22 returns 0xAB002222.
- Read 0x4000 with DEPTH_WORDS=4096, BASE_ADDR=0 -> rsp_err=1, rsp_rdata=0; a write to 0x4000 leaves word 0 unchanged.
- RD_LATENCY=0, back-to-back reads of 0x0/0x4 with req_valid held -> accepts every 2 cycles, one rsp_valid pulse per request.
- Assert reset during WAIT of a write to 0x8 -> outputs return to reset values immediately; after CLEAR, a read of 0x8 returns 0.
